// File: rtl/shift_branch_sequencer.sv
// Purpose : multi-cycle controller for the RegFile/shift/compare slice; sequences one
//           shift (SHL #8, SHL #imm) or branch (BEQ/BNE) command at a time.
// Latency : shift = accept + 4 cycles (READ, EXEC, WB, DONE); branch = accept + 3 (READ, EXEC, DONE).
// Backpressure: cmd_ready is high only in IDLE (also in DONE when SHIFT_SEQ_PIPE_ACCEPT_EN is defined);
//           cmd_* inputs are ignored whenever cmd_ready is low.
// Ports   : clock/reset (async, active-high); cmd_valid/cmd_ready/cmd_op/cmd_src/cmd_rs/cmd_rt/cmd_rd/cmd_imm
//           command handshake; rf_read1/rf_read2/rf_write_reg/rf_write_data/rf_reg_write to RegFile;
//           shift_src/shift_amt/eor_ne/ir_imm datapath selects; shifted/branch_decide from datapath;
//           result/branch_taken last outcomes; done one-cycle completion pulse.
// Config  : define SHIFT_SEQ_PIPE_ACCEPT_EN to accept the next command in the DONE cycle.
module shift_branch_sequencer #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int IMM_W  = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic              cmd_src,
    input  logic [REG_AW-1:0] cmd_rs,
    input  logic [REG_AW-1:0] cmd_rt,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic [IMM_W-1:0]  cmd_imm,
    output logic [REG_AW-1:0] rf_read1,
    output logic [REG_AW-1:0] rf_read2,
    output logic [REG_AW-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_reg_write,
    output logic              shift_src,
    output logic              shift_amt,
    output logic              eor_ne,
    output logic [IMM_W-1:0]  ir_imm,
    input  logic [DATA_W-1:0] shifted,
    input  logic              branch_decide,
    output logic [DATA_W-1:0] result,
    output logic              branch_taken,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              state_q,        state_d;
    logic                is_branch_q,    is_branch_d;
    logic [REG_AW-1:0]   rf_read1_q,     rf_read1_d;
    logic [REG_AW-1:0]   rf_read2_q,     rf_read2_d;
    logic [REG_AW-1:0]   rf_write_reg_q, rf_write_reg_d;
    logic                rf_reg_write_q, rf_reg_write_d;
    logic                shift_src_q,    shift_src_d;
    logic                shift_amt_q,    shift_amt_d;
    logic                eor_ne_q,       eor_ne_d;
    logic [IMM_W-1:0]    ir_imm_q,       ir_imm_d;
    logic [DATA_W-1:0]   result_q,       result_d;
    logic                branch_taken_q, branch_taken_d;
    logic                done_q,         done_d;
    logic                accept;

    // Ready is gated by reset so nothing can be accepted while reset is held.
`ifdef SHIFT_SEQ_PIPE_ACCEPT_EN
    assign cmd_ready = ((state_q == S_IDLE) || (state_q == S_DONE)) && !reset;
`else
    assign cmd_ready = (state_q == S_IDLE) && !reset;
`endif
    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        state_d        = state_q;
        is_branch_d    = is_branch_q;
        rf_read1_d     = rf_read1_q;
        rf_read2_d     = rf_read2_q;
        rf_write_reg_d = rf_write_reg_q;
        shift_src_d    = shift_src_q;
        shift_amt_d    = shift_amt_q;
        eor_ne_d       = eor_ne_q;
        ir_imm_d       = ir_imm_q;
        result_d       = result_q;
        branch_taken_d = branch_taken_q;
        rf_reg_write_d = 1'b0;
        done_d         = 1'b0;

        // All selects/addresses are captured at accept, so they are already
        // stable during READ and hold until the next accept.
        if (accept) begin
            is_branch_d    = cmd_op[1];
            rf_read1_d     = cmd_rs;
            rf_read2_d     = cmd_rt;
            rf_write_reg_d = cmd_rd;
            shift_src_d    = cmd_src;
            shift_amt_d    = (cmd_op == 2'b01);
            eor_ne_d       = (cmd_op == 2'b10);
            ir_imm_d       = cmd_imm;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_branch_q) begin
                    branch_taken_d = branch_decide;
                    done_d         = 1'b1;
                    state_d        = S_DONE;
                end else begin
                    result_d       = shifted;
                    rf_reg_write_d = 1'b1;
                    state_d        = S_WB;
                end
            end
            S_WB: begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = accept ? S_READ : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs: done and rf_reg_write are set on entry to their
    // state so they are glitch-free and drop asynchronously on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            is_branch_q    <= 1'b0;
            rf_read1_q     <= '0;
            rf_read2_q     <= '0;
            rf_write_reg_q <= '0;
            rf_reg_write_q <= 1'b0;
            shift_src_q    <= 1'b0;
            shift_amt_q    <= 1'b0;
            eor_ne_q       <= 1'b0;
            ir_imm_q       <= '0;
            result_q       <= '0;
            branch_taken_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            is_branch_q    <= is_branch_d;
            rf_read1_q     <= rf_read1_d;
            rf_read2_q     <= rf_read2_d;
            rf_write_reg_q <= rf_write_reg_d;
            rf_reg_write_q <= rf_reg_write_d;
            shift_src_q    <= shift_src_d;
            shift_amt_q    <= shift_amt_d;
            eor_ne_q       <= eor_ne_d;
            ir_imm_q       <= ir_imm_d;
            result_q       <= result_d;
            branch_taken_q <= branch_taken_d;
            done_q         <= done_d;
        end
    end

    assign rf_read1      = rf_read1_q;
    assign rf_read2      = rf_read2_q;
    assign rf_write_reg  = rf_write_reg_q;
    assign rf_write_data = result_q;
    assign rf_reg_write  = rf_reg_write_q;
    assign shift_src     = shift_src_q;
    assign shift_amt     = shift_amt_q;
    assign eor_ne        = eor_ne_q;
    assign ir_imm        = ir_imm_q;
    assign result        = result_q;
    assign branch_taken  = branch_taken_q;
    assign done          = done_q;

endmodule
